// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them from address 0 upward and holds the core in reset until done. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV   = 3'd1,
        WRITE  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK    = 3'd3,
`endif
        FINISH = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_reg;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [1:0]          idx_reg;
    logic [31:0]         word_reg;
    logic [31:0]         word_next;
    logic                accept;
    logic                legal_count;
    logic                last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_reg;
`endif

    assign accept      = byte_valid && byte_ready;
    assign legal_count = (word_count != '0) && (word_count <= MAX_COUNT);
    assign last_word   = (({1'b0, addr_reg} + ONE) == count_reg);

    // Byte index 0 lands in the most significant lane (big-endian packing).
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_next[31-8*gi -: 8] = (idx_reg == 2'(gi)) ? byte_data : word_reg[31-8*gi -: 8];
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            addr_reg   <= '0;
            idx_reg    <= '0;
            word_reg   <= '0;
            byte_ready <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg    <= '0;
`endif
        end else begin
            wea  <= 1'b0;
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cpu_hold <= 1'b1;
                        if (legal_count) begin
                            count_reg  <= word_count;
                            addr_reg   <= '0;
                            idx_reg    <= '0;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state_reg  <= RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xor_reg    <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        word_reg <= word_next;
                        idx_reg  <= idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_reg  <= xor_reg ^ byte_data;
`endif
                        // addra/dina only move here, so they stay stable outside write cycles.
                        if (idx_reg == 2'd3) begin
                            state_reg  <= WRITE;
                            wea        <= 1'b1;
                            byte_ready <= 1'b0;
                            addra      <= addr_reg;
                            dina       <= word_next;
                        end
                    end
                end
                WRITE: begin
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_reg  <= CHK;
                        byte_ready <= 1'b1;
`else
                        state_reg  <= FINISH;
                        done       <= 1'b1;
`endif
                    end else begin
                        addr_reg   <= addr_reg + ADDR_W'(1);
                        idx_reg    <= '0;
                        byte_ready <= 1'b1;
                        state_reg  <= RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        if (byte_data == xor_reg) begin
                            state_reg <= FINISH;
                            done      <= 1'b1;
                        end else begin
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
`endif
                FINISH: begin
                    cpu_hold  <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg  <= IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
